// File: rtl/sha256_block_sequencer.sv
// Byte-stream front end for a shared SHA-256 compression core: builds padded
// 512-bit blocks, runs the core start/done handshake and streams the digest out.
module sha256_block_sequencer #(
    parameter int unsigned CNT_W = 29
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    output logic         in_ready,
    output logic         core_start,
    output logic         core_init,
    output logic [511:0] core_block,
    input  logic         core_done,
    input  logic [255:0] core_digest,
    output logic         out_valid,
    output logic [7:0]   out_data,
    output logic         out_last,
    input  logic         out_ready,
    output logic         ovf,
    output logic         busy
);

    localparam int unsigned IDX_W        = 6;
    localparam int unsigned K_W          = 5;
    localparam int unsigned BLK_BYTES    = 64;
    localparam int unsigned LAST_LEN_IDX = 55;

    typedef enum logic [2:0] {S_FILL, S_PAD, S_ISSUE, S_WAIT, S_OUT} state_t;

    state_t              r_state, w_state_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_first, r_pad_pending, r_end63, r_final, r_ovf;
    logic [63:0][7:0]    r_blk;
    logic [255:0]        r_dig;
    logic [K_W-1:0]      r_k;
    logic                r_out_valid, r_out_last;
    logic                r_in_ready, r_core_start, r_core_init, r_busy;
    logic                w_in_ready_nxt, w_core_start_nxt, w_core_init_nxt, w_busy_nxt;
    logic                w_in_acc, w_out_acc;
    logic [63:0]         w_len;

    assign w_in_acc  = in_valid & r_in_ready & (r_state == S_FILL);
    assign w_out_acc = r_out_valid & out_ready;
    assign w_len     = 64'({r_cnt, 3'b000});

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FILL;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL:  if (w_in_acc) begin
                         if (in_last && !(&r_idx)) w_state_nxt = S_PAD;
                         else if (&r_idx)          w_state_nxt = S_ISSUE;
                     end
            S_PAD:   w_state_nxt = S_ISSUE;
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  if (core_done) begin
                         if (r_final)            w_state_nxt = S_OUT;
                         else if (r_pad_pending) w_state_nxt = S_PAD;
                         else                    w_state_nxt = S_FILL;
                     end
            S_OUT:   if (w_out_acc && r_out_last) w_state_nxt = S_FILL;
            default: w_state_nxt = S_FILL;
        endcase
    end

    // Idle means back in FILL at the start of a fresh message with nothing buffered.
    always_comb begin
        w_in_ready_nxt   = (w_state_nxt == S_FILL);
        w_core_start_nxt = (w_state_nxt == S_ISSUE);
        w_core_init_nxt  = (w_state_nxt == S_ISSUE) & r_first;
        w_busy_nxt       = !((w_state_nxt == S_FILL) &&
                             (((r_state == S_FILL) && !w_in_acc && (r_idx == '0) && r_first) ||
                              (r_state == S_OUT)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_in_ready   <= 1'b0;
            r_core_start <= 1'b0;
            r_core_init  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_in_ready   <= w_in_ready_nxt;
            r_core_start <= w_core_start_nxt;
            r_core_init  <= w_core_init_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx         <= '0;
            r_cnt         <= '0;
            r_first       <= 1'b1;
            r_pad_pending <= 1'b0;
            r_end63       <= 1'b0;
            r_final       <= 1'b0;
            r_ovf         <= 1'b0;
            r_blk         <= '0;
            r_dig         <= '0;
            r_k           <= '0;
            r_out_valid   <= 1'b0;
            r_out_last    <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: if (w_in_acc) begin
                    r_blk[~r_idx] <= in_data;
                    r_idx         <= r_idx + IDX_W'(1);
                    r_cnt         <= r_cnt + CNT_W'(1);
                    if (&r_cnt) r_ovf <= 1'b1;
                    if (in_last && (&r_idx)) begin
                        r_pad_pending <= 1'b1;
                        r_end63       <= 1'b1;
                    end
                end
                S_PAD: if (r_pad_pending) begin
                    // Extra block carrying only the length (and 0x80 if it did not fit before).
                    r_blk         <= '0;
                    r_blk[63]     <= r_end63 ? 8'h80 : 8'h00;
                    r_blk[7:0]    <= w_len;
                    r_final       <= 1'b1;
                    r_pad_pending <= 1'b0;
                end else begin
                    for (int b = 0; b < BLK_BYTES; b++) begin
                        if (IDX_W'(b) == r_idx)     r_blk[IDX_W'(63 - b)] <= 8'h80;
                        else if (IDX_W'(b) > r_idx) r_blk[IDX_W'(63 - b)] <= 8'h00;
                    end
                    if (r_idx <= IDX_W'(LAST_LEN_IDX)) begin
                        r_blk[7:0] <= w_len;
                        r_final    <= 1'b1;
                    end else begin
                        r_pad_pending <= 1'b1;
                    end
                end
                S_ISSUE: r_first <= 1'b0;
                S_WAIT: if (core_done) begin
                    if (r_final) begin
                        r_dig       <= core_digest;
                        r_out_valid <= 1'b1;
                        r_out_last  <= 1'b0;
                        r_k         <= '0;
                    end else if (!r_pad_pending) begin
                        r_idx <= '0;
                    end
                end
                S_OUT: if (w_out_acc) begin
                    r_dig      <= {r_dig[247:0], 8'h00};
                    r_k        <= r_k + K_W'(1);
                    r_out_last <= (r_k == K_W'(30));
                    if (r_out_last) begin
                        r_out_valid   <= 1'b0;
                        r_idx         <= '0;
                        r_cnt         <= '0;
                        r_first       <= 1'b1;
                        r_ovf         <= 1'b0;
                        r_end63       <= 1'b0;
                        r_final       <= 1'b0;
                        r_pad_pending <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign core_start = r_core_start;
    assign core_init  = r_core_init;
    assign core_block = r_blk;
    assign out_valid  = r_out_valid;
    assign out_data   = r_dig[255:248];
    assign out_last   = r_out_last;
    assign ovf        = r_ovf;
    assign busy       = r_busy;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// Directed bench for sha256_block_sequencer with a behavioural SHA-256 core;
// a second instance with a 4-bit byte counter exercises length overflow.
module tb_sha256_block_sequencer;

    localparam int LAT = 4;

    localparam logic [63:0][31:0] SHA_K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [255:0] SHA_IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_448 =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, in_last, in_ready, core_start, core_init, core_done;
    logic [7:0]   in_data, out_data;
    logic [511:0] core_block;
    logic [255:0] core_digest;
    logic         out_valid, out_last, out_ready, ovf, busy;

    logic         in4_valid, in4_last, in4_ready, c4_start, c4_init, c4_done;
    logic [7:0]   in4_data, out4_data;
    logic [511:0] c4_block, c4_blk_cap;
    logic [255:0] c4_digest;
    logic         out4_valid, out4_last, out4_ready, ovf4, busy4;

    sha256_block_sequencer dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .core_start(core_start), .core_init(core_init), .core_block(core_block),
        .core_done(core_done), .core_digest(core_digest), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready), .ovf(ovf), .busy(busy));

    sha256_block_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in4_valid), .in_data(in4_data), .in_last(in4_last),
        .in_ready(in4_ready), .core_start(c4_start), .core_init(c4_init), .core_block(c4_block),
        .core_done(c4_done), .core_digest(c4_digest), .out_valid(out4_valid), .out_data(out4_data),
        .out_last(out4_last), .out_ready(out4_ready), .ovf(ovf4), .busy(busy4));

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_acc_cyc = 0;
    logic [511:0] blk_q[$];
    logic         init_q[$];
    int           start_cyc_q[$];
    int           done_cyc_q[$];
    logic [7:0]   msg [0:255];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + SHA_K[63 - t] + w[t];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {a + hin[255:224], b + hin[223:192], c + hin[191:160], d + hin[159:128],
                e + hin[127:96],  f + hin[95:64],   g + hin[63:32],   h + hin[31:0]};
    endfunction

    // Behavioural compression cores: fixed latency, done pulse with the new hash state.
    initial begin : core_models
        int cnt = 0;
        int c4_cnt = 0;
        logic [255:0] pend_h = '0;
        core_done = 1'b0; core_digest = '0; c4_done = 1'b0; c4_digest = '0; c4_blk_cap = '0;
        forever begin
            @(posedge clk); #1;
            core_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    core_done = 1'b1;
                    core_digest = pend_h;
                    done_cyc_q.push_back(cyc);
                end
            end
            if (core_start) begin
                blk_q.push_back(core_block);
                init_q.push_back(core_init);
                start_cyc_q.push_back(cyc);
                pend_h = sha_compress(core_init ? SHA_IV : core_digest, core_block);
                cnt = LAT;
            end
            c4_done = 1'b0;
            if (c4_cnt > 0) begin
                c4_cnt--;
                if (c4_cnt == 0) begin
                    c4_done = 1'b1;
                    c4_digest = 256'h00112233445566778899aabbccddeeff0123456789abcdeffedcba9876543210;
                end
            end
            if (c4_start) begin
                c4_blk_cap = c4_block;
                c4_cnt = 2;
            end
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic clear_log;
        blk_q.delete(); init_q.delete(); start_cyc_q.delete(); done_cyc_q.delete();
    endtask

    task automatic send_msg(input int len, input bit gaps, input bit no_last);
        int budget;
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                step();
            end
            in_valid = 1'b1;
            in_data  = msg[i];
            in_last  = (i == len - 1) && !no_last;
            budget = 0;
            while (!in_ready && budget < 1000) begin
                step();
                budget++;
            end
            if (!in_ready) begin
                check_eq("in_ready_timeout", 512'(in_ready), 512'(1));
                break;
            end
            if (in_last) last_acc_cyc = cyc;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic get_digest(input bit stall, output logic [255:0] dig);
        int k = 0;
        int budget = 0;
        bit hold = 1'b0;
        bit stable = 1'b1, last_ok = 1'b1, rdy_ok = 1'b1;
        logic [7:0] held = '0;
        dig = '0;
        while (k < 32 && budget < 3000) begin
            if (out_valid) begin
                if (hold && out_data !== held) stable = 1'b0;
                if (in_ready !== 1'b0) rdy_ok = 1'b0;
                out_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (out_ready) begin
                    dig = {dig[247:0], out_data};
                    if (out_last !== (k == 31)) last_ok = 1'b0;
                    k++;
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    held = out_data;
                end
            end else begin
                out_ready = 1'b0;
            end
            step();
            budget++;
        end
        out_ready = 1'b0;
        check_eq("digest_byte_count", 512'(k), 512'(32));
        check_eq("out_last_position", 512'(last_ok), 512'(1));
        check_eq("out_data_stable_in_stall", 512'(stable), 512'(1));
        check_eq("in_ready_low_in_out", 512'(rdy_ok), 512'(1));
    endtask

    task automatic load_str(input string s);
        for (int i = 0; i < s.len(); i++) msg[i] = s[i];
    endtask

    initial begin : main
        logic [255:0] dig;
        logic [511:0] eb, eb2;
        int budget;
        bit quiet;
        string s56;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        in4_valid = 1'b0; in4_data = '0; in4_last = 1'b0; out4_ready = 1'b0;
        repeat (3) step();

        check_eq("rst_in_ready",   512'(in_ready),   512'(0));
        check_eq("rst_core_start", 512'(core_start), 512'(0));
        check_eq("rst_core_init",  512'(core_init),  512'(0));
        check_eq("rst_core_block", core_block,       512'(0));
        check_eq("rst_out_valid",  512'(out_valid),  512'(0));
        check_eq("rst_out_data",   512'(out_data),   512'(0));
        check_eq("rst_out_last",   512'(out_last),   512'(0));
        check_eq("rst_ovf",        512'(ovf),        512'(0));
        check_eq("rst_busy",       512'(busy),       512'(0));
        reset = 1'b0;
        check_eq("in_ready_low_at_release", 512'(in_ready), 512'(0));
        step();
        check_eq("in_ready_after_release", 512'(in_ready), 512'(1));

        // "abc": single final block
        clear_log();
        load_str("abc");
        send_msg(3, 1'b0, 1'b0);
        check_eq("abc_busy", 512'(busy), 512'(1));
        get_digest(1'b0, dig);
        check_eq("abc_digest", 512'(dig), 512'(DIG_ABC));
        check_eq("abc_starts", 512'(blk_q.size()), 512'(1));
        check_eq("abc_block", blk_q[0], {24'h616263, 8'h80, 416'h0, 64'h18});
        check_eq("abc_init", 512'(init_q[0]), 512'(1));
        check_eq("abc_start_latency", 512'(start_cyc_q[0] - last_acc_cyc), 512'(2));
        check_eq("abc_idle_after", 512'(busy), 512'(0));

        // 55 x 'a': length still fits in the first block
        clear_log();
        for (int i = 0; i < 55; i++) msg[i] = 8'h61;
        send_msg(55, 1'b0, 1'b0);
        get_digest(1'b0, dig);
        eb = {{55{8'h61}}, 8'h80, 64'h1b8};
        check_eq("a55_starts", 512'(blk_q.size()), 512'(1));
        check_eq("a55_block", blk_q[0], eb);
        check_eq("a55_digest", 512'(dig), 512'(sha_compress(SHA_IV, eb)));

        // 56-byte standard vector: length spills into a second block
        clear_log();
        s56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
        load_str(s56);
        send_msg(56, 1'b0, 1'b0);
        get_digest(1'b0, dig);
        eb = '0;
        for (int i = 0; i < 56; i++) eb[511 - 8*i -: 8] = msg[i];
        eb[511 - 8*56 -: 8] = 8'h80;
        check_eq("m56_starts", 512'(blk_q.size()), 512'(2));
        check_eq("m56_block1", blk_q[0], eb);
        check_eq("m56_block2", blk_q[1], {448'h0, 64'h1c0});
        check_eq("m56_init1", 512'(init_q[0]), 512'(1));
        check_eq("m56_init2", 512'(init_q[1]), 512'(0));
        check_eq("m56_digest", 512'(dig), 512'(DIG_448));

        // 64 bytes ending exactly at a block boundary: pad-only second block
        clear_log();
        for (int i = 0; i < 64; i++) msg[i] = 8'(i);
        send_msg(64, 1'b0, 1'b0);
        get_digest(1'b0, dig);
        eb = '0;
        for (int i = 0; i < 64; i++) eb[511 - 8*i -: 8] = 8'(i);
        eb2 = {8'h80, 440'h0, 64'h200};
        check_eq("m64_starts", 512'(blk_q.size()), 512'(2));
        check_eq("m64_block1", blk_q[0], eb);
        check_eq("m64_block2", blk_q[1], eb2);
        check_eq("m64_restart_gap", 512'(start_cyc_q[1] - done_cyc_q[0]), 512'(2));
        check_eq("m64_digest", 512'(dig), 512'(sha_compress(sha_compress(SHA_IV, eb), eb2)));

        // "abc" again with input gaps and output back-pressure
        clear_log();
        load_str("abc");
        send_msg(3, 1'b1, 1'b0);
        get_digest(1'b1, dig);
        check_eq("stall_digest", 512'(dig), 512'(DIG_ABC));

        // Reset while waiting on the core; its late done must be ignored
        clear_log();
        for (int i = 0; i < 64; i++) msg[i] = 8'h5a;
        send_msg(64, 1'b0, 1'b1);
        repeat (3) step();
        check_eq("wait_busy", 512'(busy), 512'(1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_eq("late_done_present", 512'(core_done), 512'(1));
        quiet = 1'b1;
        repeat (10) begin
            if (out_valid || core_start) quiet = 1'b0;
            step();
        end
        check_eq("no_spurious_out", 512'(quiet), 512'(1));
        check_eq("rst_mid_ovf", 512'(ovf), 512'(0));
        check_eq("rst_mid_busy", 512'(busy), 512'(0));
        clear_log();
        load_str("abc");
        send_msg(3, 1'b0, 1'b0);
        get_digest(1'b0, dig);
        check_eq("post_rst_digest", 512'(dig), 512'(DIG_ABC));
        check_eq("post_rst_init", 512'(init_q[0]), 512'(1));

        // CNT_W=4: 17 bytes wraps the counter on the 16th byte
        for (int i = 0; i < 17; i++) begin
            in4_valid = 1'b1;
            in4_data  = 8'(i);
            in4_last  = (i == 16);
            budget = 0;
            while (!in4_ready && budget < 1000) begin
                step();
                budget++;
            end
            if (i == 15) check_eq("ovf_before_wrap", 512'(ovf4), 512'(0));
            step();
        end
        in4_valid = 1'b0;
        in4_last  = 1'b0;
        check_eq("ovf_after_wrap", 512'(ovf4), 512'(1));
        budget = 0;
        while (!out4_valid && budget < 200) begin
            step();
            budget++;
        end
        check_eq("ovf4_out_valid", 512'(out4_valid), 512'(1));
        check_eq("ovf4_len_field", 512'(c4_blk_cap[63:0]), 512'(64'd8));
        check_eq("ovf4_pad_byte", 512'(c4_blk_cap[375:368]), 512'(8'h80));
        out4_ready = 1'b1;
        budget = 0;
        while (!out4_last && budget < 100) begin
            step();
            budget++;
        end
        check_eq("ovf_held_to_last", 512'(ovf4), 512'(1));
        check_eq("ovf4_last_byte", 512'(out4_data), 512'(8'h10));
        step();
        out4_ready = 1'b0;
        check_eq("ovf_cleared", 512'(ovf4), 512'(0));
        check_eq("ovf4_out_done", 512'(out4_valid), 512'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
